// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the ADC-to-FFT frame loader.
package fft_pkg;

    localparam int DATA_W     = 16;
    localparam int N_BANK     = 4;
    localparam int BANK_DEPTH = 512;
    localparam int FRAME_LEN  = 2048;

    typedef enum logic [2:0] {
        S_FILL,
        S_LAST,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/fft_adc_loader.sv
// Streams ADC samples into the FFT's banked input RAMs, launches the FFT once
// a frame is full, and holds results until the consumer re-arms the loader.
module fft_adc_loader #(
    parameter int DATA_W     = fft_pkg::DATA_W,
    parameter int N_BANK     = fft_pkg::N_BANK,
    parameter int BANK_DEPTH = fft_pkg::BANK_DEPTH
) (
    input  logic                          iCLK,
    input  logic                          iRESET,
    input  logic [DATA_W-1:0]             iDATA,
    input  logic                          iVALID,
    output logic                          oREADY,
    output logic [DATA_W-1:0]             oDATA,
    output logic [$clog2(BANK_DEPTH)-1:0] oADDR_WR_0,
    output logic [$clog2(BANK_DEPTH)-1:0] oADDR_WR_1,
    output logic [$clog2(BANK_DEPTH)-1:0] oADDR_WR_2,
    output logic [$clog2(BANK_DEPTH)-1:0] oADDR_WR_3,
    output logic [N_BANK-1:0]             oWE,
    output logic                          oSTART,
    input  logic                          iRDY,
    input  logic                          iREARM,
    output logic                          oDONE,
    output logic [15:0]                   oDROP_CNT
);
    import fft_pkg::*;

    localparam int AW    = $clog2(BANK_DEPTH);
    localparam int CNT_W = $clog2(N_BANK * BANK_DEPTH);
    localparam int BW    = CNT_W - AW;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BANK * BANK_DEPTH - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                waitFirst_q;
    logic [N_BANK-1:0]   we_q;
    logic [DATA_W-1:0]   data_q;
    logic [AW-1:0]       addr_q [N_BANK];
    logic                start_q;
    logic                done_q;
    logic [15:0]         dropCnt_q;
    logic [15:0]         dropCnt_d;
    logic [BW-1:0]       bank;
    logic                ready;
    logic                rearmNow;

    assign ready    = (state_q == S_FILL);
    assign bank     = cnt_q[CNT_W-1:AW];
    assign rearmNow = (state_q == S_DONE) && iREARM;

    // A re-arm clears the drop count, but a sample dropped in that same cycle still counts.
    always_comb begin
        dropCnt_d = dropCnt_q;
        if (rearmNow) begin
            dropCnt_d = iVALID ? 16'd1 : 16'd0;
        end else if (iVALID && !ready && (dropCnt_q != 16'hFFFF)) begin
            dropCnt_d = dropCnt_q + 16'd1;
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            waitFirst_q <= 1'b0;
            we_q        <= '0;
            data_q      <= '0;
            for (int b = 0; b < N_BANK; b++) begin
                addr_q[b] <= '0;
            end
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            dropCnt_q   <= '0;
        end else begin
            we_q      <= '0;
            start_q   <= 1'b0;
            dropCnt_q <= dropCnt_d;
            case (state_q)
                S_FILL: begin
                    if (iVALID) begin
                        data_q       <= iDATA;
                        we_q         <= N_BANK'(1) << bank;
                        addr_q[bank] <= cnt_q[AW-1:0];
                        // The counter parks on the last index; only a re-arm restarts it.
                        if (cnt_q == LAST_IDX) begin
                            state_q <= S_LAST;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_LAST: begin
                    state_q <= S_START;
                    start_q <= 1'b1;
                end
                S_START: begin
                    state_q     <= S_WAIT;
                    waitFirst_q <= 1'b1;
                end
                S_WAIT: begin
                    waitFirst_q <= 1'b0;
                    if (!waitFirst_q && iRDY) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (iREARM) begin
                        state_q <= S_FILL;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_FILL;
                end
            endcase
        end
    end

    assign oREADY     = ready;
    assign oDATA      = data_q;
    assign oWE        = we_q;
    assign oSTART     = start_q;
    assign oDONE      = done_q;
    assign oDROP_CNT  = dropCnt_q;
    assign oADDR_WR_0 = addr_q[0];
    assign oADDR_WR_1 = addr_q[1];
    assign oADDR_WR_2 = addr_q[2];
    assign oADDR_WR_3 = addr_q[3];

endmodule

// File: doc/fft_adc_loader.md
FFT_ADC_LOADER -- requirements
Module: fft_adc_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning ADC sample width.
REQ-002 SHALL have parameter N_BANK, default 4, meaning number of FFT input RAM banks.
REQ-003 SHALL have parameter BANK_DEPTH, default 512, meaning words per bank; address width is log2(BANK_DEPTH), 9 by default.
REQ-004 SHALL have port iCLK, input, 1, the single clock for all logic.
REQ-005 SHALL have port iRESET, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port iDATA, input, DATA_W, signed ADC sample.
REQ-007 SHALL have port iVALID, input, 1, iDATA valid this cycle.
REQ-008 SHALL have port oREADY, output, 1, loader accepts a sample this cycle.
REQ-009 SHALL have port oDATA, output, DATA_W, sample to the FFT iDATA port.
REQ-010 SHALL have ports oADDR_WR_0..oADDR_WR_3, output, 9 each, per-bank write address to FFT iADDR_WR_n.
REQ-011 SHALL have port oWE, output, N_BANK, one-hot per-bank write enable to FFT iWE_n.
REQ-012 SHALL have port oSTART, output, 1, one-cycle FFT launch pulse to FFT iSTART.
REQ-013 SHALL have port iRDY, input, 1, FFT oRDY (results valid).
REQ-014 SHALL have port iREARM, input, 1, pulse that releases results and restarts filling.
REQ-015 SHALL have port oDONE, output, 1, high while FFT results are held for readout.
REQ-016 SHALL have port oDROP_CNT, output, 16, count of dropped samples.

Function
REQ-017 SHALL implement FSM states S_FILL, S_LAST, S_START, S_WAIT, S_DONE.
REQ-018 oREADY SHALL equal (state == S_FILL); a sample is accepted on iVALID & oREADY.
REQ-019 Accepted sample k (k = 0..2047) SHALL be written to bank k/512, address k%512, in fill order bank0 addr0..511, then bank1 through bank3.
REQ-020 Write SHALL be registered: accepted at cycle c -> oDATA, oADDR_WR_b, and oWE[b] valid for exactly one cycle at c+1; oWE is all-zero otherwise.
REQ-021 The oADDR_WR_n of non-written banks SHALL hold their last value.
REQ-022 Acceptance of sample 2047 SHALL move S_FILL -> S_LAST, where that write is issued; S_LAST -> S_START unconditionally.
REQ-023 In S_START, oSTART SHALL be 1 for exactly one cycle (c+2 after the last accept); S_START -> S_WAIT.
REQ-024 iRDY SHALL be ignored in S_START and in the first S_WAIT cycle; afterwards iRDY = 1 moves S_WAIT -> S_DONE.
REQ-025 In S_DONE, oDONE SHALL be 1; iREARM = 1 moves to S_FILL with the sample counter at 0; iREARM in any other state SHALL be ignored.
REQ-026 iVALID = 1 while oREADY = 0 SHALL drop the sample and increment oDROP_CNT, saturating at 0xFFFF.
REQ-027 iREARM accepted in S_DONE SHALL clear oDROP_CNT; a drop in that same cycle SHALL count as 1 after the clear.
REQ-028 The sample counter SHALL be 11 bits, wrap from 2047 to 0 only via S_DONE -> S_FILL, and SHALL never advance outside S_FILL.

Reset
REQ-029 iRESET SHALL asynchronously force: state S_FILL, sample counter 0, oWE 0, oSTART 0, oDONE 0, oDATA 0, all oADDR_WR_n 0, oDROP_CNT 0.
REQ-030 Reset asserted mid-fill or mid-FFT SHALL discard the partial frame, and no oSTART SHALL follow until 2048 new samples are accepted.
REQ-031 oREADY SHALL be 1 in the first cycle after reset release.

Structure
REQ-032 A shared package fft_pkg SHALL hold DATA_W, N_BANK, BANK_DEPTH, FRAME_LEN = 2048, and the state enum typedef.
REQ-033 The block SHALL be a single module with no sub-modules; the drop counter may be an inline saturating counter.

Verification
REQ-034 Verification SHALL cover: 2048 consecutive valid samples of value 100 -> bank0..3 addresses 0..511 each contain 100, oSTART is high once at 2 cycles after the last accept, and oREADY = 0 afterward.
REQ-035 Verification SHALL cover: ramp data with iVALID toggled every other cycle -> sample k lands at bank k/512, address k%512, with oWE one-hot and 1-cycle latency.
REQ-036 Verification SHALL cover: iRDY held at 1 during S_START -> no S_DONE until the second S_WAIT cycle; a later iRDY pulse -> oDONE = 1.
REQ-037 Verification SHALL cover: 10 valid samples sent in S_WAIT/S_DONE -> oDROP_CNT = 10; iREARM -> oDROP_CNT = 0, oREADY = 1, and the next sample is written to bank0 address 0.
REQ-038 Verification SHALL cover: iRESET asserted after 700 samples -> outputs are at reset values immediately; 2048 fresh samples -> exactly one oSTART.
REQ-039 Verification SHALL cover: iREARM pulsed in S_FILL -> no effect, and the sample count continues.
